// File: rtl/tenbaset_rxd.sv
// 10BASE-T Manchester receiver: 8x oversampling, mid-bit edge bit recovery, preamble/SFD hunt,
// LSB-first byte assembly and CRC-32 residue check on carrier loss.
module tenbaset_rxd (
  input  logic       clk80,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_crc_ok,
  output logic       rx_dribble,
  output logic       rx_busy
);
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_HUNT     = 2'd1;
  localparam logic [1:0]  ST_DATA     = 2'd2;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic        s1_q, s2_q, s3_q;
  logic [4:0]  cnt_q, cnt_d;
  logic        mid_q, bit_q;
  logic [1:0]  state_q, state_d;
  logic        prev_q, prev_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] crc_q, crc_d, crc_step;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        crc_ok_q, crc_ok_d;
  logic        drib_q, drib_d;
  logic        edge_w, mid_w, loss_w;

  // Edges closer than 6 samples to the last mid-bit edge are bit-boundary transitions or noise.
  assign edge_w = s2_q ^ s3_q;
  assign mid_w  = edge_w && (cnt_q >= 5'd6);
  // Fires as cnt steps to 20; an edge in the same cycle clears cnt instead and wins.
  assign loss_w = !mid_w && (cnt_q == 5'd19);

  always_comb begin
    cnt_d = cnt_q;
    if (mid_w)
      cnt_d = 5'd0;
    else if (cnt_q != 5'd31)
      cnt_d = cnt_q + 5'd1;
  end

  assign crc_step = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ bit_q) ? CRC_POLY : 32'd0);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    pre_cnt_d = pre_cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    crc_ok_d  = crc_ok_q;
    drib_d    = drib_q;
    case (state_q)
      ST_IDLE: begin
        if (mid_q) begin
          state_d   = ST_HUNT;
          prev_d    = bit_q;
          pre_cnt_d = 4'd1;
        end
      end
      ST_HUNT: begin
        if (loss_w) begin
          state_d   = ST_IDLE;
          pre_cnt_d = 4'd0;
        end else if (mid_q) begin
          prev_d = bit_q;
          if (bit_q != prev_q) begin
            if (pre_cnt_q != 4'd15)
              pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (bit_q && (pre_cnt_q >= 4'd7)) begin
            state_d   = ST_DATA;
            sof_d     = 1'b1;
            crc_ok_d  = 1'b0;
            drib_d    = 1'b0;
            crc_d     = 32'hFFFF_FFFF;
            bitcnt_d  = 3'd0;
            pre_cnt_d = 4'd0;
          end else begin
            pre_cnt_d = 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (loss_w) begin
          state_d  = ST_IDLE;
          eof_d    = 1'b1;
          crc_ok_d = (crc_q == CRC_RESIDUE);
          drib_d   = (bitcnt_q != 3'd0);
        end else if (mid_q) begin
          shift_d  = {bit_q, shift_q[7:1]};
          crc_d    = crc_step;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            data_d  = shift_d;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk80 or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      cnt_q     <= 5'd31;
      mid_q     <= 1'b0;
      bit_q     <= 1'b0;
      state_q   <= ST_IDLE;
      prev_q    <= 1'b0;
      pre_cnt_q <= 4'd0;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'd0;
      crc_q     <= 32'hFFFF_FFFF;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      crc_ok_q  <= 1'b0;
      drib_q    <= 1'b0;
    end else begin
      s1_q      <= RxD;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      mid_q     <= mid_w;
      bit_q     <= s2_q;
      state_q   <= state_d;
      prev_q    <= prev_d;
      pre_cnt_q <= pre_cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      crc_ok_q  <= crc_ok_d;
      drib_q    <= drib_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_sof     = sof_q;
  assign rx_eof     = eof_q;
  assign rx_crc_ok  = crc_ok_q;
  assign rx_dribble = drib_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tenbaset_rxd.sv
// Directed sequence of Manchester frames and link pulses with random payloads, jitter and an aborting reset.
module tb_tenbaset_rxd;
  logic       clk80 = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_dribble, rx_busy;

  tenbaset_rxd dut (
    .clk80(clk80), .reset(reset), .RxD(RxD),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_crc_ok(rx_crc_ok), .rx_dribble(rx_dribble), .rx_busy(rx_busy)
  );

  always #5 clk80 = ~clk80;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk80) cyc <= cyc + 1;

  // Receive-side record, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         n_sof = 0, n_eof = 0, sof_cyc = 0;
  logic       eof_crc = 1'b0, eof_drib = 1'b0, sof_crc = 1'b0, sof_drib = 1'b0;
  always @(negedge clk80) begin
    if (!reset) begin
      if (rx_valid) begin got_q.push_back(rx_data); got_cyc.push_back(cyc); end
      if (rx_sof)   begin n_sof++; sof_cyc = cyc; sof_crc = rx_crc_ok; sof_drib = rx_dribble; end
      if (rx_eof)   begin n_eof++; eof_crc = rx_crc_ok; eof_drib = rx_dribble; end
    end
  end

  logic [7:0] tx_bytes[$];
  bit         data_bits[$];
  int         mid_cyc[$];
  bit         abort_tx = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input bit b);
    return (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB88320 : 32'h0);
  endfunction

  // 64 random payload bytes followed by the Ethernet FCS (complemented CRC, low byte first).
  task automatic make_frame();
    logic [31:0] c;
    logic [7:0]  b;
    tx_bytes = {};
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      tx_bytes.push_back(b);
      for (int j = 0; j < 8; j++) c = crc_upd(c, b[j]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) tx_bytes.push_back(8'(c >> (8 * i)));
  endtask

  task automatic send_frame(input int extra, input bit jit);
    bit         bits[$];
    logic [7:0] b8;
    int         per, h1, h2, prev_h2;
    bit         bv;
    bits = {};
    data_bits = {};
    mid_cyc = {};
    prev_h2 = 4;
    for (int i = 0; i < 8; i++) begin
      b8 = (i == 7) ? 8'hD5 : 8'h55;
      for (int j = 0; j < 8; j++) bits.push_back(b8[j]);
    end
    foreach (tx_bytes[i]) begin
      b8 = tx_bytes[i];
      for (int j = 0; j < 8; j++) begin bits.push_back(b8[j]); data_bits.push_back(b8[j]); end
    end
    for (int i = 0; i < extra; i++) begin
      bv = ($urandom_range(0, 1) != 0);
      bits.push_back(bv);
      data_bits.push_back(bv);
    end
    foreach (bits[i]) begin
      if (abort_tx) break;
      if (jit) begin
        // Periods alternate 7/9 cycles; mid edge wanders +/-1 but stays >= 7 cycles from the previous one.
        per = (i % 2 == 0) ? 7 : 9;
        h1  = per / 2 + int'($urandom_range(0, 2)) - 1;
        if (prev_h2 + h1 < 7) h1 = 7 - prev_h2;
      end else begin
        per = 8;
        h1  = 4;
      end
      h2 = per - h1;
      prev_h2 = h2;
      for (int k = 0; k < h1 + h2; k++) begin
        @(negedge clk80);
        if (abort_tx) break;
        RxD = (k < h1) ? ~bits[i] : bits[i];
        if (k == h1) mid_cyc.push_back(cyc);
      end
    end
    @(negedge clk80);
    RxD = 1'b1;
    repeat (40) @(negedge clk80);
  endtask

  task automatic check_frame(input string ft, input int v0, input int s0, input int e0);
    int          nexp;
    logic [7:0]  b;
    logic [31:0] c;
    bit          ok;
    nexp = data_bits.size() / 8;
    c = 32'hFFFF_FFFF;
    foreach (data_bits[i]) c = crc_upd(c, data_bits[i]);
    ok = (c == 32'hDEBB20E3);
    chk({ft, "/sof_count"}, 32'(n_sof - s0), 32'd1);
    chk({ft, "/valid_count"}, 32'(got_q.size() - v0), 32'(nexp));
    for (int i = 0; i < nexp && v0 + i < got_q.size(); i++) begin
      for (int j = 0; j < 8; j++) b[j] = data_bits[8 * i + j];
      chk({ft, "/byte"}, 32'(got_q[v0 + i]), 32'(b));
    end
    chk({ft, "/eof_count"}, 32'(n_eof - e0), 32'd1);
    chk({ft, "/crc_ok"}, 32'(eof_crc), 32'(ok));
    chk({ft, "/dribble"}, 32'(eof_drib), 32'(data_bits.size() % 8 != 0));
    chk({ft, "/crc_ok_held"}, 32'(rx_crc_ok), 32'(ok));
    chk({ft, "/flags_clear_at_sof"}, 32'({sof_crc, sof_drib}), 32'd0);
    // Drive cycle N -> first sampling edge N+1 -> strobe visible 3 edges later.
    chk({ft, "/sof_latency"}, 32'(sof_cyc - mid_cyc[63]), 32'd4);
    if (got_cyc.size() > v0)
      chk({ft, "/valid_latency"}, 32'(got_cyc[v0] - mid_cyc[71]), 32'd4);
    chk({ft, "/busy_after"}, 32'(rx_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string ft);
    chk({ft, "/rx_data"}, 32'(rx_data), 32'd0);
    chk({ft, "/strobes"}, 32'({rx_valid, rx_sof, rx_eof}), 32'd0);
    chk({ft, "/flags"}, 32'({rx_crc_ok, rx_dribble}), 32'd0);
    chk({ft, "/busy"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int  v0, s0, e0, idx, waited;
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk80);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk80);

    // Link pulses: 8-cycle excursion on the idle line must never start a frame.
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk80); RxD = 1'b0;
      repeat (8) @(negedge clk80); RxD = 1'b1;
      repeat (10) @(negedge clk80);
      chk("pulse/busy_hunting", 32'(rx_busy), 32'd1);
      repeat (13) @(negedge clk80);
      chk("pulse/busy_released", 32'(rx_busy), 32'd0);
      repeat (150) @(negedge clk80);
    end
    chk("pulse/no_activity", 32'((got_q.size() - v0) + (n_sof - s0) + (n_eof - e0)), 32'd0);

    make_frame();
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    send_frame(0, 1'b0);
    check_frame("good", v0, s0, e0);

    make_frame();
    idx = $urandom_range(0, 511);
    tx_bytes[idx / 8] = tx_bytes[idx / 8] ^ (8'h01 << (idx % 8));
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    send_frame(0, 1'b0);
    check_frame("bitflip", v0, s0, e0);

    make_frame();
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    send_frame(3, 1'b0);
    check_frame("dribble", v0, s0, e0);

    make_frame();
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    send_frame(0, 1'b1);
    check_frame("jitter", v0, s0, e0);

    // Reset in the middle of payload byte 10, then a clean frame.
    make_frame();
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    fork
      send_frame(0, 1'b0);
      begin
        waited = 0;
        while (got_q.size() < v0 + 10 && waited < 3000) begin
          @(negedge clk80);
          waited++;
        end
        chk("abort/reached_byte10", 32'(got_q.size() >= v0 + 10), 32'd1);
        repeat (30) @(negedge clk80);
        reset = 1'b1;
        abort_tx = 1'b1;
        repeat (2) @(negedge clk80);
        check_reset_outputs("abort_reset");
        repeat (4) @(negedge clk80);
        reset = 1'b0;
      end
    join
    repeat (40) @(negedge clk80);
    chk("abort/no_eof", 32'(n_eof - e0), 32'd0);
    chk("abort/idle", 32'(rx_busy), 32'd0);
    abort_tx = 1'b0;

    make_frame();
    v0 = got_q.size(); s0 = n_sof; e0 = n_eof;
    send_frame(0, 1'b0);
    check_frame("after_reset", v0, s0, e0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
